// File: rtl/alu_seq_pipe.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | Module      : alu_seq_pipe                                                |
// | Description : Registered ALU with valid/ready handshakes on both sides,   |
// |               multi-cycle shift-add multiply and result flags.            |
// | Revision    : 1.0 - initial release                                       |
// +---------------------------------------------------------------------------+
module alu_seq_pipe #(
  parameter int WIDTH    = 32,
  parameter int MUL_STEP = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       Selector_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] resultado,
  output logic             ZeroFlag,
  output logic             NegFlag,
  output logic             CarryFlag,
  output logic             OvfFlag,
  output logic             IllegalOp
);

  localparam int SHW   = $clog2(WIDTH);
  localparam int STEPS = WIDTH / MUL_STEP;
  localparam int CNTW  = $clog2(STEPS) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] a_sh, b_bits, acc, acc_nxt, partial;
  logic [CNTW-1:0]  cnt;
  logic [WIDTH:0]   add_full;
  logic [WIDTH-1:0] diff, alu_res, load_val;
  logic [SHW-1:0]   shamt;
  logic             alu_c, alu_v, alu_ill;
  logic             mul_start, load_alu, load_mul;

  // Single-cycle operations, evaluated straight from the handshake inputs.
  always_comb begin
    add_full = {1'b0, A} + {1'b0, B};
    diff     = A - B;
    shamt    = B[SHW-1:0];
    alu_res  = '0;
    alu_c    = 1'b0;
    alu_v    = 1'b0;
    alu_ill  = 1'b0;
    case (Selector_op)
      4'b0000: begin
        alu_res = add_full[WIDTH-1:0];
        alu_c   = add_full[WIDTH];
        alu_v   = (A[WIDTH-1] == B[WIDTH-1]) && (add_full[WIDTH-1] != A[WIDTH-1]);
      end
      4'b0001: begin
        alu_res = diff;
        alu_c   = (A >= B);
        alu_v   = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
      end
      4'b0010: alu_res = '0;
      4'b0011: alu_res = {{(WIDTH-1){1'b0}}, (A < B)};
      4'b0100: alu_res = A & B;
      4'b0101: alu_res = A | B;
      4'b0110: alu_res = A << shamt;
      4'b0111: alu_res = A ^ B;
      4'b1000: alu_res = '0;
      4'b1001: alu_res = A >> shamt;
      4'b1010: alu_res = $signed(A) >>> shamt;
      4'b1011: alu_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      default: alu_ill = 1'b1;
    endcase
  end

  // One shift-add step: MUL_STEP multiplier bits against the shifted multiplicand.
  always_comb begin
    partial = '0;
    for (int j = 0; j < MUL_STEP; j++) begin
      if (b_bits[j]) partial = partial + (a_sh << j);
    end
    acc_nxt = acc + partial;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    mul_start = 1'b0;
    load_alu  = 1'b0;
    load_mul  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (Selector_op == 4'b0010) begin
            mul_start = 1'b1;
            state_nxt = MUL;
          end else begin
            load_alu  = 1'b1;
            state_nxt = DONE;
          end
        end
      end
      MUL: begin
        if (cnt == CNTW'(1)) begin
          load_mul  = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign load_val = load_mul ? acc_nxt : alu_res;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh      <= '0;
      b_bits    <= '0;
      acc       <= '0;
      cnt       <= '0;
      resultado <= '0;
      ZeroFlag  <= 1'b1;
      NegFlag   <= 1'b0;
      CarryFlag <= 1'b0;
      OvfFlag   <= 1'b0;
      IllegalOp <= 1'b0;
    end else begin
      if (mul_start) begin
        a_sh   <= A;
        b_bits <= B;
        acc    <= '0;
        cnt    <= CNTW'(STEPS);
      end else if (state == MUL) begin
        a_sh   <= a_sh << MUL_STEP;
        b_bits <= b_bits >> MUL_STEP;
        acc    <= acc_nxt;
        cnt    <= cnt - 1'b1;
      end
      // Result and flags only move on load, so they hold under back-pressure.
      if (load_alu || load_mul) begin
        resultado <= load_val;
        ZeroFlag  <= (load_val == '0);
        NegFlag   <= load_val[WIDTH-1];
        CarryFlag <= load_alu & alu_c;
        OvfFlag   <= load_alu & alu_v;
        IllegalOp <= load_alu & alu_ill;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_seq_pipe.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | Module      : tb_alu_seq_pipe                                             |
// | Description : Directed vector bench for alu_seq_pipe.                     |
// | Revision    : 1.0 - initial release                                       |
// +---------------------------------------------------------------------------+
module tb_alu_seq_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] A, B, resultado;
  logic [3:0]  Selector_op;
  logic        ZeroFlag, NegFlag, CarryFlag, OvfFlag, IllegalOp;
  logic        in_valid4, in_ready4, out_valid4;
  logic [31:0] resultado4;
  logic        z4, n4, c4, v4, ill4;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu_seq_pipe #(.WIDTH(32), .MUL_STEP(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .Selector_op(Selector_op), .out_valid(out_valid),
    .out_ready(out_ready), .resultado(resultado), .ZeroFlag(ZeroFlag),
    .NegFlag(NegFlag), .CarryFlag(CarryFlag), .OvfFlag(OvfFlag), .IllegalOp(IllegalOp)
  );

  alu_seq_pipe #(.WIDTH(32), .MUL_STEP(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
    .A(A), .B(B), .Selector_op(Selector_op), .out_valid(out_valid4),
    .out_ready(1'b1), .resultado(resultado4), .ZeroFlag(z4),
    .NegFlag(n4), .CarryFlag(c4), .OvfFlag(v4), .IllegalOp(ill4)
  );

  // flg order: {Zero, Neg, Carry, Ovf, Illegal}; lat = edges after accept to out_valid
  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    logic [31:0] res;
    logic [4:0]  flg;
    int          lat;
  } vec_t;

  vec_t vt[18];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_op(input bit s4, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] op, output int lat);
    int w;
    w = 0;
    @(negedge clk);
    while (!(s4 ? in_ready4 : in_ready) && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (w >= 200) chk("in_ready_wait", 64'(w), 64'(0));
    A = a; B = b; Selector_op = op;
    if (s4) in_valid4 = 1'b1;
    else    in_valid  = 1'b1;
    @(negedge clk);
    in_valid  = 1'b0;
    in_valid4 = 1'b0;
    lat = 0;
    while (!(s4 ? out_valid4 : out_valid) && lat < 200) begin
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat;
    vt[0]  = '{32'hFFFF_FFFF, 32'h1,         4'h0, 32'h0,         5'b10100, 0};
    vt[1]  = '{32'h8000_0000, 32'h1,         4'h1, 32'h7FFF_FFFF, 5'b00110, 0};
    vt[2]  = '{32'h8000_0000, 32'h21,        4'hA, 32'hC000_0000, 5'b01000, 0};
    vt[3]  = '{32'h8000_0000, 32'h21,        4'h9, 32'h4000_0000, 5'b00000, 0};
    vt[4]  = '{32'h8000_0000, 32'h21,        4'h6, 32'h0,         5'b10000, 0};
    vt[5]  = '{32'hFFFF_FFFF, 32'h1,         4'hB, 32'h1,         5'b00000, 0};
    vt[6]  = '{32'hFFFF_FFFF, 32'h1,         4'h3, 32'h0,         5'b10000, 0};
    vt[7]  = '{32'h1234_5678, 32'h9,         4'hF, 32'h0,         5'b10001, 0};
    vt[8]  = '{32'hF0F0_F0F0, 32'h0FF0_0FF0, 4'h4, 32'h00F0_00F0, 5'b00000, 0};
    vt[9]  = '{32'hF0F0_F0F0, 32'h0F0F_0000, 4'h5, 32'hFFFF_F0F0, 5'b01000, 0};
    vt[10] = '{32'hFFFF_0000, 32'hFF00_FF00, 4'h7, 32'h00FF_FF00, 5'b00000, 0};
    vt[11] = '{32'h1234,      32'h5678,      4'h8, 32'h0,         5'b10000, 0};
    vt[12] = '{32'h1,         32'h2,         4'h1, 32'hFFFF_FFFF, 5'b01000, 0};
    vt[13] = '{32'h7FFF_FFFF, 32'h1,         4'h0, 32'h8000_0000, 5'b01010, 0};
    vt[14] = '{32'h1234_5678, 32'h20,        4'h6, 32'h1234_5678, 5'b00000, 0};
    vt[15] = '{32'h0001_0003, 32'h5,         4'h2, 32'h0005_000F, 5'b00000, 32};
    vt[16] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'h2, 32'h1,         5'b00000, 32};
    vt[17] = '{32'h5,         32'h5,         4'h1, 32'h0,         5'b10100, 0};

    rst_n = 1'b0; in_valid = 1'b0; in_valid4 = 1'b0; out_ready = 1'b1;
    A = '0; B = '0; Selector_op = '0;
    repeat (3) @(negedge clk);
    chk("reset_state", {out_valid, resultado, ZeroFlag, NegFlag, CarryFlag, OvfFlag, IllegalOp},
        {1'b0, 32'h0, 5'b10000});
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_in_ready", 64'(in_ready), 64'(1));

    for (int i = 0; i < 18; i++) begin
      run_op(1'b0, vt[i].a, vt[i].b, vt[i].op, lat);
      chk($sformatf("vec%0d_lat", i), 64'(lat), 64'(vt[i].lat));
      chk($sformatf("vec%0d_res_flags", i),
          {resultado, ZeroFlag, NegFlag, CarryFlag, OvfFlag, IllegalOp},
          {vt[i].res, vt[i].flg});
    end

    run_op(1'b1, 32'h0001_0003, 32'h5, 4'h2, lat);
    chk("mul_step4_lat", 64'(lat), 64'(8));
    chk("mul_step4_res", {resultado4, z4, n4, c4, v4, ill4}, {32'h0005_000F, 5'b00000});

    // Back-pressure: DONE held, competing request must be ignored.
    out_ready = 1'b0;
    run_op(1'b0, 32'h2, 32'h3, 4'h0, lat);
    chk("bp_lat", 64'(lat), 64'(0));
    for (int i = 0; i < 5; i++) begin
      A = 32'h9; B = 32'h9; Selector_op = 4'h0; in_valid = 1'b1;
      @(negedge clk);
      chk($sformatf("bp_hold%0d", i),
          {out_valid, in_ready, resultado, ZeroFlag, NegFlag, CarryFlag, OvfFlag, IllegalOp},
          {1'b1, 1'b0, 32'h5, 5'b00000});
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release", {out_valid, in_ready}, {1'b0, 1'b1});
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("bp_no_stray%0d", i), 64'(out_valid), 64'(0));
    end

    // Reset in the middle of a multiply (cnt=10 after 22 steps).
    A = 32'h0001_0003; B = 32'h5; Selector_op = 4'h2; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (22) @(negedge clk);
    chk("mid_mul_busy", {out_valid, in_ready}, {1'b0, 1'b0});
    rst_n = 1'b0;
    #1;
    chk("mid_mul_reset", {out_valid, resultado, ZeroFlag}, {1'b0, 32'h0, 1'b1});
    @(negedge clk);
    rst_n = 1'b1;
    run_op(1'b0, 32'h2, 32'h3, 4'h0, lat);
    chk("post_reset_add", {32'(lat), resultado}, {32'd0, 32'h5});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
